// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run controller that resets, runs, freezes and dumps a single-cycle CPU
// Ports: clk/reset (async active-low) | start begins a run from IDLE or DONE
//        cpu_pc in, cpu_reset/cpu_en out: CPU control | rf_raddr/rf_rdata: debug register read
//        dump_valid/dump_ready/dump_data/dump_last: 33-word result stream (x0..x31, cycle count)
//        cycle_count/busy/done/timeout: run status
module cpu_run_ctrl #(
    parameter logic [63:0] END_PC     = 64'd60,
    parameter int unsigned MAX_CYCLES = 1000,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [63:0]      cpu_pc,
    output logic             cpu_reset,
    output logic             cpu_en,
    output logic [4:0]       rf_raddr,
    input  logic [63:0]      rf_rdata,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [63:0]      dump_data,
    output logic             dump_last,
    output logic [CNT_W-1:0] cycle_count,
    output logic             busy,
    output logic             done,
    output logic             timeout
);
    localparam int RC_W = $clog2(RST_CYCLES + 1);
    typedef enum logic [2:0] {S_IDLE, S_RST, S_RUN, S_DUMP_REG, S_DUMP_CNT, S_DONE} state_e;
    state_e            state_q, state_d;
    logic [RC_W-1:0]   rc_q, rc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [4:0]        raddr_q, raddr_d;
    logic              timeout_q, timeout_d;
    assign cnt_inc = cnt_q + CNT_W'(1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            rc_q      <= '0;
            cnt_q     <= '0;
            raddr_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rc_q      <= rc_d;
            cnt_q     <= cnt_d;
            raddr_q   <= raddr_d;
            timeout_q <= timeout_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        rc_d      = rc_q;
        cnt_d     = cnt_q;
        raddr_d   = raddr_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) begin
                state_d   = S_RST;
                rc_d      = RC_W'(RST_CYCLES - 1);
                cnt_d     = '0;
                timeout_d = 1'b0;
            end
            S_RST: if (rc_q == '0) state_d = S_RUN; else rc_d = rc_q - RC_W'(1);
            S_RUN: begin
                cnt_d = cnt_inc;
                // end-of-program wins over budget expiry on the same edge
                if (cpu_pc >= END_PC) begin
                    state_d   = S_DUMP_REG;
                    timeout_d = 1'b0;
                end else if (cnt_inc == CNT_W'(MAX_CYCLES)) begin
                    state_d   = S_DUMP_REG;
                    timeout_d = 1'b1;
                end
            end
            // raddr wraps 31 -> 0 naturally, leaving it at 0 for the next run
            S_DUMP_REG: if (dump_ready) begin
                raddr_d = raddr_q + 5'd1;
                if (raddr_q == 5'd31) state_d = S_DUMP_CNT;
            end
            S_DUMP_CNT: if (dump_ready) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end
    // cpu_reset is released from RUN onward so the frozen register file survives the dump
    assign cpu_reset   = (state_q == S_IDLE) || (state_q == S_RST);
    assign cpu_en      = state_q == S_RUN;
    assign rf_raddr    = raddr_q;
    assign dump_valid  = (state_q == S_DUMP_REG) || (state_q == S_DUMP_CNT);
    assign dump_last   = state_q == S_DUMP_CNT;
    assign dump_data   = state_q == S_DUMP_REG ? rf_rdata : state_q == S_DUMP_CNT ? 64'(cnt_q) : '0;
    assign cycle_count = cnt_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done        = state_q == S_DONE;
    assign timeout     = timeout_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed bench for cpu_run_ctrl (end-PC run and budget timeout side by side)
module tb_cpu_run_ctrl;
    localparam logic [63:0] BASE_M = 64'hFEED_0000_0000_0000;
    localparam logic [63:0] BASE_T = 64'hBEEF_0000_0000_0000;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset, start, dump_ready;
    logic [63:0] pc_m = '0, pc_t;
    logic m_cpu_reset, m_cpu_en, m_valid, m_last, m_busy, m_done, m_to;
    logic t_cpu_reset, t_cpu_en, t_valid, t_last, t_busy, t_done, t_to;
    logic [4:0] m_raddr, t_raddr;
    logic [63:0] m_rdata, t_rdata, m_data, t_data;
    logic [31:0] m_cnt, t_cnt;
    int n_checks = 0, n_fail = 0;
    logic [63:0] words_m[40], words_t[40];
    logic last_m[40], last_t[40];
    int n_m, n_t, rst_m, run_m, run_t, stall_bad;

    function automatic logic [63:0] rf_val(input logic [63:0] base, input logic [4:0] a);
        return base + 64'(a) * 64'h0000_0001_0000_0101;
    endfunction

    assign m_rdata = rf_val(BASE_M, m_raddr);
    assign t_rdata = rf_val(BASE_T, t_raddr);
    assign pc_t = 64'd8;
    always @(posedge clk) if (m_cpu_reset) pc_m <= '0; else if (m_cpu_en) pc_m <= pc_m + 64'd4;

    cpu_run_ctrl #(.END_PC(64'd60), .MAX_CYCLES(16), .CNT_W(32), .RST_CYCLES(2)) u_dut_m (
        .clk(clk), .reset(reset), .start(start), .cpu_pc(pc_m),
        .cpu_reset(m_cpu_reset), .cpu_en(m_cpu_en), .rf_raddr(m_raddr), .rf_rdata(m_rdata),
        .dump_valid(m_valid), .dump_ready(dump_ready), .dump_data(m_data), .dump_last(m_last),
        .cycle_count(m_cnt), .busy(m_busy), .done(m_done), .timeout(m_to));

    cpu_run_ctrl #(.END_PC(64'd60), .MAX_CYCLES(10), .CNT_W(32), .RST_CYCLES(2)) u_dut_t (
        .clk(clk), .reset(reset), .start(start), .cpu_pc(pc_t),
        .cpu_reset(t_cpu_reset), .cpu_en(t_cpu_en), .rf_raddr(t_raddr), .rf_rdata(t_rdata),
        .dump_valid(t_valid), .dump_ready(dump_ready), .dump_data(t_data), .dump_last(t_last),
        .cycle_count(t_cnt), .busy(t_busy), .done(t_done), .timeout(t_to));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_once(input bit bp, input bit hold, input int abort_at);
        logic m_stall = 1'b0, t_stall = 1'b0;
        logic [63:0] pd_m = '0, pd_t = '0;
        logic [4:0] pa_m = '0, pa_t = '0;
        bit fin = 1'b0;
        n_m = 0; n_t = 0; rst_m = 0; run_m = 0; run_t = 0; stall_bad = 0;
        for (int k = 0; k < 40; k++) begin
            words_m[k] = '1; words_t[k] = '1; last_m[k] = 1'b0; last_t[k] = 1'b0;
        end
        start = 1'b1;
        dump_ready = 1'b1;
        @(posedge clk); #1;
        check("cnt_cleared", 64'(m_cnt), 64'd0);
        check("done_cleared", 64'(m_done), 64'd0);
        check("busy_in_rst", 64'(m_busy), 64'd1);
        if (!hold) start = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            dump_ready = bp ? (cyc % 3 == 0) : 1'b1;
            if (hold && m_valid) start = 1'b0;
            @(negedge clk);
            if (m_busy && m_cpu_reset) rst_m++;
            if (m_cpu_en) run_m++;
            if (t_cpu_en) run_t++;
            if (m_stall && (m_data !== pd_m || m_raddr !== pa_m)) stall_bad++;
            if (t_stall && (t_data !== pd_t || t_raddr !== pa_t)) stall_bad++;
            if (m_valid && dump_ready && n_m < 40) begin words_m[n_m] = m_data; last_m[n_m] = m_last; n_m++; end
            if (t_valid && dump_ready && n_t < 40) begin words_t[n_t] = t_data; last_t[n_t] = t_last; n_t++; end
            m_stall = m_valid && !dump_ready; pd_m = m_data; pa_m = m_raddr;
            t_stall = t_valid && !dump_ready; pd_t = t_data; pa_t = t_raddr;
            if (abort_at >= 0 && n_m == abort_at + 1) fin = 1'b1;
            else if (m_done && t_done) fin = 1'b1;
            if (!fin) begin @(posedge clk); #1; end
        end
        start = 1'b0;
    endtask

    task automatic verify(input string name);
        int bad_m = 0, bad_t = 0, lst = 0;
        check({name, "_rst_cycles"}, 64'(rst_m), 64'd2);
        check({name, "_run_cycles"}, 64'(run_m), 64'd16);
        check({name, "_cycle_count"}, 64'(m_cnt), 64'd16);
        check({name, "_timeout"}, 64'(m_to), 64'd0);
        check({name, "_words"}, 64'(n_m), 64'd33);
        check({name, "_done"}, 64'(m_done), 64'd1);
        check({name, "_busy"}, 64'(m_busy), 64'd0);
        check({name, "_frozen_en"}, 64'(m_cpu_en), 64'd0);
        check({name, "_cpu_reset"}, 64'(m_cpu_reset), 64'd0);
        check({name, "_stall_stable"}, 64'(stall_bad), 64'd0);
        for (int k = 0; k < 32; k++) begin
            if (words_m[k] !== rf_val(BASE_M, 5'(k))) bad_m++;
            if (words_t[k] !== rf_val(BASE_T, 5'(k))) bad_t++;
            if (last_m[k] || last_t[k]) lst++;
        end
        check({name, "_reg_words"}, 64'(bad_m), 64'd0);
        check({name, "_early_last"}, 64'(lst), 64'd0);
        check({name, "_cnt_word"}, words_m[32], 64'd16);
        check({name, "_last_flag"}, 64'(last_m[32]), 64'd1);
        check({name, "_to_run_cycles"}, 64'(run_t), 64'd10);
        check({name, "_to_cycle_count"}, 64'(t_cnt), 64'd10);
        check({name, "_to_timeout"}, 64'(t_to), 64'd1);
        check({name, "_to_words"}, 64'(n_t), 64'd33);
        check({name, "_to_reg_words"}, 64'(bad_t), 64'd0);
        check({name, "_to_cnt_word"}, words_t[32], 64'd10);
        check({name, "_to_last_flag"}, 64'(last_t[32]), 64'd1);
        check({name, "_to_done"}, 64'(t_done), 64'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_cpu_reset"}, 64'(m_cpu_reset), 64'd1);
        check({name, "_cpu_en"}, 64'(m_cpu_en), 64'd0);
        check({name, "_raddr"}, 64'(m_raddr), 64'd0);
        check({name, "_valid"}, 64'(m_valid), 64'd0);
        check({name, "_last"}, 64'(m_last), 64'd0);
        check({name, "_data"}, m_data, 64'd0);
        check({name, "_cnt"}, 64'(m_cnt), 64'd0);
        check({name, "_done"}, 64'(m_done), 64'd0);
        check({name, "_timeout"}, 64'(m_to), 64'd0);
        check({name, "_busy"}, 64'(m_busy), 64'd0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        dump_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_no_start", 64'(m_busy), 64'd0);
        run_once(1'b0, 1'b0, -1);
        verify("basic");
        run_once(1'b1, 1'b0, -1);
        verify("bp");
        run_once(1'b1, 1'b0, 5);
        @(posedge clk); #2;
        check("pre_rst_raddr", 64'(m_raddr), 64'd6);
        check("pre_rst_valid", 64'(m_valid), 64'd1);
        reset = 1'b0;
        #1;
        check_reset_outputs("async");
        check("async_to_cnt", 64'(t_cnt), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run_once(1'b0, 1'b0, -1);
        verify("post_rst");
        run_once(1'b0, 1'b1, -1);
        verify("restart");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run controller for the single-cycle CPU (top_cpu).
- Holds the CPU in reset, releases it, and gates its clock enable while counting executed cycles.
- Freezes the CPU when the PC reaches the end-of-program address or a cycle budget expires.
- Streams the 32 architectural registers and the final cycle count out over a valid/ready port. This is the in-silicon equivalent of the simulation completion/dump flow.

Parameters:
- END_PC, 64'd60: program complete when cpu_pc >= END_PC (unsigned).
- MAX_CYCLES, 1000: run budget in cycles; must be >= 1 and < 2^CNT_W.
- CNT_W, 32: cycle counter width, 1..64.
- RST_CYCLES, 2: cycles cpu_reset is held high after start; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  level-sampled; begins a run from IDLE or DONE.
- cpu_pc  in  64  current CPU program counter.
- cpu_reset  out  1  active-high reset to top_cpu.
- cpu_en  out  1  CPU state-update enable (PC, register file, data memory writes).
- rf_raddr  out  5  debug read address into the register file.
- rf_rdata  in  64  combinational register read data for rf_raddr.
- dump_valid  out  1  dump word available.
- dump_ready  in  1  sink accepts the word.
- dump_data  out  64  dump word.
- dump_last  out  1  marks the final (cycle-count) word.
- cycle_count  out  CNT_W  RUN cycles executed.
- busy  out  1  state is not IDLE and not DONE.
- done  out  1  run and dump complete.
- timeout  out  1  run ended by MAX_CYCLES rather than END_PC.

Behaviour:
- States: IDLE, RST, RUN, DUMP_REG, DUMP_CNT, DONE. The state register is updated only on the clk rising edge, except for asynchronous reset.
- Reset (reset=0, asynchronous, any time including mid-run or mid-dump):
  - state=IDLE; cpu_reset=1; cpu_en=0; rf_raddr=0; dump_valid=0; dump_last=0; dump_data=0; cycle_count=0; done=0; timeout=0; busy=0.
  - Any in-flight dump word is dropped.
- IDLE:
  - cpu_reset=1, cpu_en=0.
  - start=1 -> RST: reset-hold counter loaded, cycle_count, done and timeout cleared.
- RST:
  - cpu_reset=1 for exactly RST_CYCLES clocks, then -> RUN.
- RUN:
  - cpu_reset=0, cpu_en=1.
  - Every RUN edge increments cycle_count by 1. The count includes the terminating edge.
  - Terminating edge: cpu_pc >= END_PC -> DUMP_REG, timeout=0.
  - Otherwise, if cycle_count+1 == MAX_CYCLES -> DUMP_REG, timeout=1.
  - The PC check has priority when both conditions hold on the same edge.
  - start is ignored.
- Freeze on exit from RUN:
  - cpu_en=0 from the first DUMP_REG cycle onward, so the PC and registers stay frozen.
  - cpu_reset stays 0 so register contents are preserved.
- DUMP_REG:
  - dump_valid=1, dump_data=rf_rdata, dump_last=0.
  - rf_raddr starts at 0.
  - On dump_valid & dump_ready: rf_raddr increments. If rf_raddr==31, -> DUMP_CNT and rf_raddr wraps to 0.
  - While dump_ready=0, rf_raddr and dump_data stay stable.
- DUMP_CNT:
  - dump_valid=1, dump_data = cycle_count zero-extended to 64, dump_last=1.
  - On accept -> DONE.
- DONE:
  - done=1, dump_valid=0, cpu_en=0, cpu_reset=0.
  - cycle_count and timeout are held.
  - start=1 -> RST (new run) and clears done, cycle_count and timeout.
- Handshake:
  - Exactly 33 words per run, in order x0..x31 then the count.
  - Once asserted, dump_valid is never deasserted before acceptance.
  - dump_ready is ignored when dump_valid=0.
- Counter arithmetic: cycle_count cannot wrap, because MAX_CYCLES < 2^CNT_W bounds it.
- busy=1 in RST, RUN, DUMP_REG and DUMP_CNT.

Test Plan:
- Basic run:
  - Stimulus: bench PC model starts at 0 and adds 4 per cpu_en cycle; start pulsed; dump_ready tied 1.
  - Required: cpu_reset high for 2 cycles; 16 RUN cycles (PC 0..60); cycle_count=16; timeout=0; 33 words; word 32 = 16 with dump_last=1; done=1.
- Backpressure:
  - Stimulus: dump_ready toggled 1,0,0,1,... during the dump.
  - Required: dump_data and rf_raddr stable while stalled; word k equals model register k; no word lost or duplicated.
- Timeout:
  - Stimulus: MAX_CYCLES=10; PC model stuck at 8.
  - Required: exit after 10 RUN cycles; cycle_count=10; timeout=1; last word = 10.
- Priority:
  - Stimulus: MAX_CYCLES=16, END_PC=60; PC reaches 60 on the 16th cycle.
  - Required: timeout=0.
- Async reset mid-dump:
  - Stimulus: reset=0 after word 5 is accepted, with no clock edge.
  - Required: outputs take reset values immediately; dump_valid=0; a later start gives a full clean run with count 16.
- Restart and ignore:
  - Stimulus: start held high throughout RUN; then start asserted in DONE.
  - Required: no effect during RUN; from DONE, a second run starts with cycle_count cleared to 0 and produces an identical dump.
